// File: rtl/demux1_2_sequential_if.sv
// demux1_2_sequential_if: stream bundle between a 1:2 registered demux and its environment
// Signals:
//   valid_in, data_in[WIDTH]    incoming word and its qualifier
//   mode, selector              steering control (0 = external select, 1 = auto-alternate)
//   data_out0/1[WIDTH]          registered lane data
//   valid_out0/1                per-lane update pulses
//   pair_valid                  both lanes updated together (auto-alternate)
//   lane_drop                   held half-pair discarded by a mode change
// Modports: master drives the inputs and observes the outputs; slave is the demux side.
interface demux1_2_sequential_if #(parameter int WIDTH = 2);
    logic             valid_in;
    logic [WIDTH-1:0] data_in;
    logic             mode;
    logic             selector;
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic             valid_out0;
    logic             valid_out1;
    logic             pair_valid;
    logic             lane_drop;
    modport master (
        output valid_in, data_in, mode, selector,
        input  data_out0, data_out1, valid_out0, valid_out1, pair_valid, lane_drop
    );
    modport slave (
        input  valid_in, data_in, mode, selector,
        output data_out0, data_out1, valid_out0, valid_out1, pair_valid, lane_drop
    );
endinterface

// File: rtl/demux1_2_sequential.sv
// demux1_2_sequential: registered 1:2 demux, external-select or auto-alternate pairing
// Ports:
//   clk      rising-edge clock
//   reset_L  synchronous active-low reset
//   bus      demux1_2_sequential_if.slave (inputs valid_in/data_in/mode/selector,
//            outputs data_out0/1, valid_out0/1, pair_valid, lane_drop)
module demux1_2_sequential #(
    parameter int WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    demux1_2_sequential_if.slave  bus
);
    typedef enum logic {LANE0, LANE1} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
    logic             v0_q, v0_d, v1_q, v1_d, pv_q, pv_d, drop_q, drop_d;
    logic             mode_q;
    logic             mode_chg;
    state_t           cur;
    // A mode change restarts pairing; the word at that edge is handled under the new mode.
    assign mode_chg = bus.mode != mode_q;
    assign cur      = mode_chg ? LANE0 : state_q;
    always_comb begin
        state_d = cur;
        hold_d  = hold_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        pv_d    = 1'b0;
        drop_d  = mode_chg && state_q == LANE1;
        if (bus.valid_in) begin
            if (!bus.mode) begin
                out0_d = bus.selector ? out0_q : bus.data_in;
                out1_d = bus.selector ? bus.data_in : out1_q;
                v0_d   = !bus.selector;
                v1_d   = bus.selector;
            end else if (cur == LANE0) begin
                hold_d  = bus.data_in;
                state_d = LANE1;
            end else begin
                out0_d  = hold_q;
                out1_d  = bus.data_in;
                v0_d    = 1'b1;
                v1_d    = 1'b1;
                pv_d    = 1'b1;
                state_d = LANE0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= LANE0;
            hold_q  <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            pv_q    <= 1'b0;
            drop_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            pv_q    <= pv_d;
            drop_q  <= drop_d;
            mode_q  <= bus.mode;
        end
    end
    assign bus.data_out0  = out0_q;
    assign bus.data_out1  = out1_q;
    assign bus.valid_out0 = v0_q;
    assign bus.valid_out1 = v1_q;
    assign bus.pair_valid = pv_q;
    assign bus.lane_drop  = drop_q;
endmodule

// File: tb/tb_demux1_2_sequential.sv
// tb_demux1_2_sequential: directed plus random stimulus against a queue-based reference model
// Ports: none (drives clk/reset_L and a demux1_2_sequential_if master).
module tb_demux1_2_sequential;
    logic clk = 1'b0;
    logic reset_L;
    int   checks = 0;
    int   errors = 0;
    demux1_2_sequential_if #(.WIDTH(2)) bus ();
    demux1_2_sequential #(.WIDTH(2)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));
    always #5 clk = ~clk;
    logic [1:0] m_out0, m_out1;
    logic       m_v0, m_v1, m_pv, m_drop, m_mode;
    logic [1:0] pend[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic rn, input logic v, input logic [1:0] d, input logic m, input logic s);
        reset_L      = rn;
        bus.valid_in = v;
        bus.data_in  = d;
        bus.mode     = m;
        bus.selector = s;
        @(posedge clk);
        m_v0 = 0; m_v1 = 0; m_pv = 0; m_drop = 0;
        if (!rn) begin
            m_out0 = 0; m_out1 = 0; m_mode = 0;
            pend.delete();
        end else begin
            if (m != m_mode) begin
                m_drop = pend.size() != 0;
                pend.delete();
            end
            m_mode = m;
            if (v) begin
                if (!m) begin
                    if (s) begin m_out1 = d; m_v1 = 1; end
                    else   begin m_out0 = d; m_v0 = 1; end
                end else if (pend.size() == 0) pend.push_back(d);
                else begin
                    m_out0 = pend.pop_front();
                    m_out1 = d;
                    m_v0 = 1; m_v1 = 1; m_pv = 1;
                end
            end
        end
        #1;
        check("data_out0",  bus.data_out0,  m_out0);
        check("data_out1",  bus.data_out1,  m_out1);
        check("valid_out0", bus.valid_out0, m_v0);
        check("valid_out1", bus.valid_out1, m_v1);
        check("pair_valid", bus.pair_valid, m_pv);
        check("lane_drop",  bus.lane_drop,  m_drop);
    endtask
    initial begin
        cyc(0, 1, 2'b11, 0, 0);
        cyc(0, 1, 2'b11, 0, 0);
        check("rst_out0", bus.data_out0, 2'b00);
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 0, 2'b00, 0, 0);
        check("idle_v0", bus.valid_out0, 1'b0);
        cyc(1, 1, 2'b01, 0, 0);
        check("m0_out0", bus.data_out0, 2'b01);
        cyc(1, 1, 2'b10, 0, 1);
        check("m0_out1", bus.data_out1, 2'b10);
        check("m0_out0_hold", bus.data_out0, 2'b01);
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 1, 2'b11, 1, 0);
        check("m1_odd_pv", bus.pair_valid, 1'b0);
        cyc(1, 1, 2'b00, 1, 0);
        check("m1_pair1", {bus.pair_valid, bus.data_out0, bus.data_out1}, 5'b1_11_00);
        cyc(1, 1, 2'b10, 1, 0);
        cyc(1, 1, 2'b01, 1, 0);
        check("m1_pair2", {bus.pair_valid, bus.data_out0, bus.data_out1}, 5'b1_10_01);
        cyc(1, 1, 2'b10, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'b00, 1, 0);
        cyc(1, 1, 2'b11, 1, 0);
        check("gap_pair", {bus.pair_valid, bus.data_out0, bus.data_out1}, 5'b1_10_11);
        cyc(1, 1, 2'b01, 1, 0);
        cyc(1, 1, 2'b11, 0, 1);
        check("chg_drop", {bus.lane_drop, bus.valid_out1, bus.data_out1}, 4'b1_1_11);
        cyc(1, 1, 2'b10, 1, 0);
        cyc(1, 1, 2'b00, 1, 0);
        check("fresh_pair", {bus.pair_valid, bus.data_out0, bus.data_out1}, 5'b1_10_00);
        cyc(1, 1, 2'b01, 1, 0);
        cyc(0, 0, 2'b00, 1, 0);
        cyc(1, 1, 2'b10, 1, 0);
        cyc(1, 1, 2'b11, 1, 0);
        check("rst_pair", {bus.lane_drop, bus.pair_valid, bus.data_out0, bus.data_out1}, 6'b0_1_10_11);
        begin
            logic m = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 7) == 0) m = ~m;
                cyc($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
                    2'($urandom), m, 1'($urandom));
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux1_2_sequential.md
Name: demux1_2_sequential

Overview:
- Registered 1:2 demultiplexer: the receive-side counterpart of the registered 2:1 mux. It steers one WIDTH-bit input stream onto two output lanes.
- Two steering modes:
  - External-select mode: one word is routed per cycle by the selector input.
  - Auto-alternate mode: consecutive valid words are de-interleaved into lane0/lane1 pairs, and the pair is presented together.
- Sits downstream of a mux-based serialiser and restores the two original lanes.

Parameters:
- WIDTH, 2, data width of the input and of each output lane.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset_L  input  1  synchronous, active-low reset, sampled on posedge clk.
- valid_in  input  1  data_in carries a valid word this cycle.
- data_in  input  WIDTH  input word.
- mode  input  1  0 = external-select, 1 = auto-alternate.
- selector  input  1  lane select in mode 0; ignored in mode 1.
- data_out0  output  WIDTH  lane0 registered data.
- data_out1  output  WIDTH  lane1 registered data.
- valid_out0  output  1  data_out0 updated this cycle (1-cycle pulse).
- valid_out1  output  1  data_out1 updated this cycle (1-cycle pulse).
- pair_valid  output  1  mode 1 only: both lanes updated together this cycle.
- lane_drop  output  1  1-cycle pulse: a held half-pair was discarded.

Behaviour:
- Reset:
  - All state is updated only on posedge clk.
  - reset_L==0 at an edge forces data_out0, data_out1, valid_out0, valid_out1, pair_valid and lane_drop to 0.
  - It also clears the internal hold register to 0, sets the FSM to LANE0 and clears mode_q to 0.
  - Reset wins over every other input.
  - Reset asserted mid-pair discards the held word without a lane_drop pulse.
- Valid/pulse outputs (valid_out0, valid_out1, pair_valid, lane_drop) default to 0 every cycle unless set below. data_out0/data_out1 hold their value when not written.
- mode_q: a registered copy of mode, updated every non-reset cycle.
- Mode change: when mode != mode_q at an edge:
  - The FSM returns to LANE0.
  - lane_drop=1 if the FSM was in LANE1.
  - The input word at that edge is processed under the new mode value. In mode 1 this means a valid word goes into hold and the FSM goes to LANE1.
- Mode 0 (external-select), latency 1 cycle:
  - valid_in=1, selector=0: data_out0<=data_in, valid_out0<=1.
  - valid_in=1, selector=1: data_out1<=data_in, valid_out1<=1.
  - The lane not selected holds its data and its valid is 0.
  - valid_in=0: no data change, all valids 0.
  - The FSM stays in LANE0 and pair_valid stays 0.
- Mode 1 (auto-alternate), FSM states LANE0 and LANE1:
  - LANE0 with valid_in=1: hold<=data_in, go to LANE1, no output change.
  - LANE1 with valid_in=1: data_out0<=hold, data_out1<=data_in, and valid_out0, valid_out1, pair_valid all 1 for one cycle; go to LANE0.
  - valid_in=0 in either state: stay in the state, keep hold, outputs quiet. Gaps between the halves of a pair are allowed and unbounded.
  - Pair latency: 1 cycle after the second word is accepted.
  - Back-to-back pairs run at full rate: one pair completes every 2 valid cycles.
- Width rule: data is passed unmodified; no arithmetic.
- Simultaneous events:
  - Mode change plus valid_in: handled as described under Mode change.
  - Reset plus anything: reset wins.

Test Plan:
- Reset: hold reset_L=0 for 2 cycles with valid_in=1, data_in=2'b11 -> all outputs 0; release reset -> outputs stay 0 until the first valid word.
- Mode 0 routing: send data_in=2'b01 with sel=0, then 2'b10 with sel=1, then valid_in=0.
  - Cycle 1: data_out0=01, valid_out0=1.
  - Cycle 2: data_out1=10, valid_out1=1, data_out0 still 01.
  - Cycle 3: both valids 0.
- Mode 1 pairs: stream 2'b11, 2'b00, 2'b10, 2'b01 back-to-back.
  - After word 2: data_out0=11, data_out1=00 with pair_valid=1.
  - After word 4: data_out0=10, data_out1=01 with pair_valid=1.
  - pair_valid is 0 on the odd cycles.
- Mode 1 gap: send 2'b10, then 3 idle cycles, then 2'b11 -> a single pair 10/11, with no output activity during the idle cycles.
- Mode change mid-pair: in mode 1, send 2'b01 (FSM to LANE1), then switch mode=0 with valid_in=1, sel=1, data_in=2'b11.
  - That edge: lane_drop=1, data_out1=11, valid_out1=1.
  - Returning to mode 1 later starts a fresh pair.
- Reset mid-pair: in mode 1, send 2'b01, pulse reset_L=0, then send 2'b10, 2'b11 -> a single pair 10/11; no lane_drop; the old 01 never appears.
